// File: rtl/scaler_pkg.sv
// scaler_pkg
// Shared definitions for the scaler channel-read path: half/full snapshot
// widths, the reader FSM state encoding and the packed snapshot type.
// Used by scaler_strobe_timer and scaler_channel_reader.
package scaler_pkg;

    localparam int SCALER_HALF_W = 14;
    localparam int SCALER_W      = 28;

    // Two GAP states so the FSM knows which read follows the gap:
    // GAP_B leads into RDB, GAP_A leads into RDA2.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RDA1  = 3'd1,
        ST_GAP_B = 3'd2,
        ST_RDB   = 3'd3,
        ST_GAP_A = 3'd4,
        ST_RDA2  = 3'd5,
        ST_DONE  = 3'd6
    } scr_state_e;

    // Snapshot layout: high half (channel 3) above low half (channel 4).
    typedef struct packed {
        logic [SCALER_HALF_W-1:0] a;
        logic [SCALER_HALF_W-1:0] b;
    } scaler_snap_t;

endpackage

// File: rtl/scaler_strobe_timer.sv
// scaler_strobe_timer
// SETTLE-cycle down-counter shared by both channel reads. While `active` is
// high the strobe window is open; `sample` pulses in the last window cycle so
// the bus is captured on the edge that closes the window. The counter reloads
// whenever the window is closed, so each read starts from a full count.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   active    : a read state is current
//   window    : strobe window (drive the selected strobe low)
//   sample    : last cycle of the window; capture data on this edge
module scaler_strobe_timer
    import scaler_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic window,
    output logic sample
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LOAD = CW'(SETTLE - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || !active || count == '0) begin
            count <= LOAD;
        end else begin
            count <= count - CW'(1);
        end
    end

    assign window = active;
    assign sample = active && (count == '0);

endmodule

// File: rtl/scaler_channel_reader.sv
// scaler_channel_reader
// Reads the high half (channel 3, RCHAT_/CHAT) and low half (channel 4,
// RCHBT_/CHBT) of the scaler and builds an untorn 28-bit snapshot {A, B}.
// The high half is read before and after the low half; if it moved, the low
// half is re-read (up to MAX_RETRY times) before giving up with snap_err.
// Optional feature: define SCR_DELTA_EN to add the `delta` output, the
// difference (mod 2^28) between this snapshot and the last accepted one.
// Ports:
//   rst, CLOCK          : synchronous active-high reset, clock
//   req                 : snapshot request, taken only in IDLE
//   busy                : not idle
//   RCHAT_, RCHBT_      : active-low read strobes, never low together
//   CHAT, CHBT          : returned half-scaler buses
//   snap, snap_err      : snapshot and retries-exhausted flag
//   snap_valid/ready    : handshake; transfer when valid && ready. valid is
//                         held, with snap/snap_err stable, until ready is seen.
//   delta               : (SCR_DELTA_EN only) snapshot difference
//   state_dbg           : current FSM state
module scaler_channel_reader
    import scaler_pkg::*;
#(
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic                     rst,
    input  logic                     CLOCK,
    input  logic                     req,
    output logic                     busy,
    output logic                     RCHAT_,
    output logic                     RCHBT_,
    input  logic [SCALER_HALF_W-1:0] CHAT,
    input  logic [SCALER_HALF_W-1:0] CHBT,
    output logic [SCALER_W-1:0]      snap,
    output logic                     snap_err,
    output logic                     snap_valid,
    input  logic                     snap_ready,
`ifdef SCR_DELTA_EN
    output logic [SCALER_W-1:0]      delta,
`endif
    output logic [2:0]               state_dbg
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    scr_state_e state, state_next;

    logic [SCALER_HALF_W-1:0] a1;
    logic [SCALER_HALF_W-1:0] b_half;
    logic [RW-1:0]            retries;
    scaler_snap_t             snap_r;
    logic                     err_r;

    logic rd_a, rd_b, window, sample;
    logic a_match, exhausted;
    logic take_a1, take_b, do_retry, do_finish, accept, handshake;

    assign rd_a = (state == ST_RDA1) || (state == ST_RDA2);
    assign rd_b = (state == ST_RDB);

    scaler_strobe_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (CLOCK),
        .rst    (rst),
        .active (rd_a || rd_b),
        .window (window),
        .sample (sample)
    );

    assign a_match   = (CHAT == a1);
    assign exhausted = (retries == RETRY_LIMIT);

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        take_a1    = 1'b0;
        take_b     = 1'b0;
        do_retry   = 1'b0;
        do_finish  = 1'b0;
        handshake  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_next = ST_RDA1;
                end
            end
            ST_RDA1: begin
                if (sample) begin
                    take_a1    = 1'b1;
                    state_next = ST_GAP_B;
                end
            end
            ST_GAP_B: state_next = ST_RDB;
            ST_RDB: begin
                if (sample) begin
                    take_b     = 1'b1;
                    state_next = ST_GAP_A;
                end
            end
            ST_GAP_A: state_next = ST_RDA2;
            ST_RDA2: begin
                if (sample) begin
                    // Unchanged high half, or no retries left: publish.
                    if (a_match || exhausted) begin
                        do_finish  = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        do_retry   = 1'b1;
                        state_next = ST_GAP_B;
                    end
                end
            end
            ST_DONE: begin
                if (snap_ready) begin
                    handshake  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef SCR_DELTA_EN
    logic [SCALER_W-1:0] prev_snap;
    logic                have_prev;
    logic [SCALER_W-1:0] delta_r;
`endif

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            a1      <= '0;
            b_half  <= '0;
            retries <= '0;
            snap_r  <= '0;
            err_r   <= 1'b0;
`ifdef SCR_DELTA_EN
            prev_snap <= '0;
            have_prev <= 1'b0;
            delta_r   <= '0;
`endif
        end else begin
            if (accept) begin
                retries <= '0;
            end
            if (take_a1) begin
                a1 <= CHAT;
            end
            if (take_b) begin
                b_half <= CHBT;
            end
            if (do_retry) begin
                // The newest high half becomes the reference for the next pass.
                a1      <= CHAT;
                retries <= retries + RW'(1);
            end
            if (do_finish) begin
                snap_r <= '{a: CHAT, b: b_half};
                err_r  <= !a_match;
`ifdef SCR_DELTA_EN
                delta_r <= have_prev ? ({CHAT, b_half} - prev_snap) : '0;
`endif
            end
            if (handshake) begin
                err_r <= 1'b0;
`ifdef SCR_DELTA_EN
                prev_snap <= snap_r;
                have_prev <= 1'b1;
`endif
            end
        end
    end

    assign busy       = (state != ST_IDLE);
    assign snap_valid = (state == ST_DONE);
    assign RCHAT_     = !(window && rd_a);
    assign RCHBT_     = !(window && rd_b);
    assign snap       = snap_r;
    assign snap_err   = err_r;
    assign state_dbg  = state;
`ifdef SCR_DELTA_EN
    assign delta      = delta_r;
`endif

endmodule
